uart_instr_loader: RTL and testbench
====================================

Name: uart_instr_loader

Overview:
Boot-time loader and run gate for TOP_CPU. It pairs bytes from the UART receiver into 16-bit instruction words and writes them into instruction memory, starting at BASE_ADDR. Loading ends on a HALT word or after an idle timeout. It then reports done and the highest address written, and releases the CPU to run only when the user start level is applied.

Parameters:
ADDR_W, 8, instruction memory address width
BASE_ADDR, 1, address of the first loaded word
HALT_BYTE, 8'hE0, first (high) byte value that marks a HALT word
IDLE_TIMEOUT, 2000000, cycles without a byte, after at least one word, that end loading

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_rx_data  in  8  received byte from the UART receiver
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_start_cpu  in  1  user start level
o_mem_we  out  1  one-cycle instruction memory write strobe
o_mem_addr  out  ADDR_W  write address
o_mem_wdata  out  16  write data, {high byte, low byte}
o_instr_transmit_done  out  1  loading finished
o_max_addr  out  ADDR_W  last address written (0 = nothing loaded)
o_overflow  out  1  words were dropped because address space was exhausted
o_cpu_run  out  1  CPU enable

Behaviour:
- Reset (async, i_rst=1), all outputs 0:
  - o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_instr_transmit_done=0, o_max_addr=0, o_overflow=0, o_cpu_run=0.
  - State WAIT_HI; write pointer=BASE_ADDR; idle counter=0; word counter=0.
- Reset mid-load discards the partial byte and all progress. Memory contents are not cleared.
- States: WAIT_HI, WAIT_LO, DONE, RUN.
- WAIT_HI: on i_rx_valid, latch the byte as the high byte -> WAIT_LO.
- WAIT_LO: on i_rx_valid:
  - Issue the write registered: o_mem_we=1 for exactly one cycle, the cycle after the strobe.
  - o_mem_addr=pointer; o_mem_wdata={hi,lo}; o_max_addr=pointer, updated in the same cycle as o_mem_we.
  - Increment the pointer.
  - If hi==HALT_BYTE -> DONE, else -> WAIT_HI.
  - A strobe in the write cycle is accepted normally as the next high byte; no byte is lost.
- Address exhaustion:
  - A word completing when the pointer has already passed 2^ADDR_W-1 (pointer held 1 bit wider) is not written.
  - o_overflow=1 (sticky until reset); state -> DONE.
- Idle timeout:
  - The counter runs in WAIT_HI/WAIT_LO only when word counter>0; it clears on every i_rx_valid.
  - Reaching IDLE_TIMEOUT -> DONE; a pending high byte is discarded.
  - With no word loaded, the loader waits forever.
- DONE:
  - o_instr_transmit_done=1, registered and asserted the cycle after the final write or the timeout.
  - All i_rx_valid ignored. i_start_cpu=1 -> RUN.
- RUN:
  - o_cpu_run=1 (registered, 1-cycle latency); o_instr_transmit_done stays 1.
  - i_start_cpu=0 -> DONE, o_cpu_run=0 the next cycle.
- i_start_cpu before DONE is ignored; it does not truncate loading.
- Reload only via reset. o_mem_addr/o_mem_wdata hold their last values between writes.

Test Plan:
- Reset, send 18 bytes {41,FF,11,7F,81,80,41,FF,10,80,81,C0,40,C0,40,20,E0,00} -> 9 writes at addr 1..9; addr 9 data=16'hE000; done=1 one cycle after that write; o_max_addr=9; no further writes.
- After done, send 2 more bytes -> no o_mem_we; o_max_addr stays 9.
- Send 2 words without HALT, wait IDLE_TIMEOUT (set 1000 in bench) -> done=1 at exactly cycle 1000 after the last strobe; o_max_addr=2. Repeat with a trailing single byte -> that byte is discarded, o_max_addr=2.
- Raise i_start_cpu before done -> o_cpu_run=0. Raise it after done -> o_cpu_run=1 next cycle. Drop it -> o_cpu_run=0 next cycle, done stays 1.
- ADDR_W=3, BASE_ADDR=1, send 8 non-HALT words -> writes at 1..7, 8th word dropped, o_overflow=1, done=1, o_max_addr=7.
- Assert i_rst after 1.5 words -> all outputs 0. Then send {41,00} -> write at addr 1, data 16'h4100.

Source files
------------

// File: rtl/uart_instr_loader_if.sv
// uart_instr_loader_if
//   Bundles the byte stream coming from the UART receiver and the
//   instruction-memory write bus produced by the loader.
//   master : loader side (consumes rx bytes, drives memory writes)
//   slave  : environment side (UART receiver + instruction memory)
//   rx_data/rx_valid   byte and its one-cycle strobe
//   mem_we/addr/wdata  one-cycle write strobe, address, {hi,lo} data
interface uart_instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_instr_loader.sv
// uart_instr_loader
//   Boot-time loader and run gate. Pairs UART bytes (high first) into
//   16-bit words and writes them to instruction memory from BASE_ADDR up.
//   Loading ends on a word whose high byte is HALT_BYTE, on address
//   exhaustion, or after IDLE_TIMEOUT quiet cycles once a word has landed.
//   The CPU is then released while i_start_cpu is held high.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   bus (master)            rx byte stream in, memory write bus out
//   i_start_cpu             user start level
//   o_instr_transmit_done   loading finished (sticky until reset)
//   o_max_addr              last address written, 0 if none
//   o_overflow              a word was dropped for lack of address space
//   o_cpu_run               CPU enable
module uart_instr_loader #(
  parameter int         ADDR_W       = 8,
  parameter int         BASE_ADDR    = 1,
  parameter logic [7:0] HALT_BYTE    = 8'hE0,
  parameter int         IDLE_TIMEOUT = 2000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_instr_loader_if.master  bus,
  input  logic                 i_start_cpu,
  output logic                 o_instr_transmit_done,
  output logic [ADDR_W-1:0]    o_max_addr,
  output logic                 o_overflow,
  output logic                 o_cpu_run
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {WAIT_HI, WAIT_LO, DONE, RUN} state_e;

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  // one bit wider than the address so running past the top is visible
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [IW-1:0]     idle_q, idle_d;
  // only "at least one word written" matters for the idle timer
  logic              loaded_q, loaded_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] max_q, max_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              run_q, run_d;
  logic              timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= WAIT_HI;
      hi_q     <= '0;
      ptr_q    <= (ADDR_W+1)'(BASE_ADDR);
      idle_q   <= '0;
      loaded_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      ptr_q    <= ptr_d;
      idle_q   <= idle_d;
      loaded_q <= loaded_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      run_q    <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    ptr_d    = ptr_q;
    idle_d   = idle_q;
    loaded_d = loaded_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    max_d    = max_q;
    ovf_d    = ovf_q;
    timeout  = 1'b0;

    case (state_q)
      WAIT_HI: begin
        if (bus.rx_valid) begin
          hi_d    = bus.rx_data;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (bus.rx_valid) begin
          if (ptr_q[ADDR_W]) begin
            // no address left for this word: drop it and stop loading
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            we_d     = 1'b1;
            addr_d   = ptr_q[ADDR_W-1:0];
            wdata_d  = {hi_q, bus.rx_data};
            max_d    = ptr_q[ADDR_W-1:0];
            ptr_d    = ptr_q + 1'b1;
            loaded_d = 1'b1;
            state_d  = (hi_q == HALT_BYTE) ? DONE : WAIT_HI;
          end
        end
      end
      DONE: begin
        if (i_start_cpu) state_d = RUN;
      end
      RUN: begin
        if (!i_start_cpu) state_d = DONE;
      end
    endcase

    // Idle timer: only while loading and only once a word has landed.
    // Firing overrides a pending high byte, which is simply abandoned.
    if (state_q == WAIT_HI || state_q == WAIT_LO) begin
      if (bus.rx_valid) begin
        idle_d = '0;
      end else if (loaded_q) begin
        if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    end

    // done follows the final write by a cycle; a timeout raises it directly
    done_d = done_q | (state_q == DONE) | timeout;
    run_d  = (state_d == RUN);
  end

  assign bus.mem_we            = we_q;
  assign bus.mem_addr          = addr_q;
  assign bus.mem_wdata         = wdata_q;
  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_q;
  assign o_overflow            = ovf_q;
  assign o_cpu_run             = run_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// tb_uart_instr_loader
//   Two loaders share one stimulus stream: an 8-bit-address instance and a
//   3-bit-address instance (the latter runs out of space after 7 words).
//   A write-list model derived from the byte stream predicts writes,
//   max address, overflow and done for each instance.
module tb_uart_instr_loader;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;

  always #5 clk = ~clk;

  uart_instr_loader_if #(.ADDR_W(8)) if_a ();
  uart_instr_loader_if #(.ADDR_W(3)) if_b ();

  assign if_a.rx_data  = rx_data;
  assign if_a.rx_valid = rx_valid;
  assign if_b.rx_data  = rx_data;
  assign if_b.rx_valid = rx_valid;

  logic       done_a, ovf_a, run_a;
  logic [7:0] max_a;
  logic       done_b, ovf_b, run_b;
  logic [2:0] max_b;

  uart_instr_loader #(.ADDR_W(8), .BASE_ADDR(1), .HALT_BYTE(8'hE0), .IDLE_TIMEOUT(TO)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(if_a), .i_start_cpu(start),
    .o_instr_transmit_done(done_a), .o_max_addr(max_a),
    .o_overflow(ovf_a), .o_cpu_run(run_a)
  );

  uart_instr_loader #(.ADDR_W(3), .BASE_ADDR(1), .HALT_BYTE(8'hE0), .IDLE_TIMEOUT(TO)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(if_b), .i_start_cpu(start),
    .o_instr_transmit_done(done_b), .o_max_addr(max_b),
    .o_overflow(ovf_b), .o_cpu_run(run_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: {addr[15:0], data[15:0]} per cycle with mem_we high.
  logic [31:0] wq_a[$];
  logic [31:0] wq_b[$];
  int cyc = 0;
  int last_we_a = 0;
  int done_rise_a = 0;
  bit seen_a = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      wq_a.delete();
      wq_b.delete();
      seen_a = 0;
    end else begin
      if (if_a.mem_we) begin
        wq_a.push_back({8'h00, if_a.mem_addr, if_a.mem_wdata});
        last_we_a = cyc;
      end
      if (if_b.mem_we) wq_b.push_back({13'h0, if_b.mem_addr, if_b.mem_wdata});
      if (done_a && !seen_a) begin
        seen_a = 1;
        done_rise_a = cyc;
      end
    end
  end

  // Model: bytes pair up high-first; word k lands at 1+k unless that is
  // beyond 2^aw-1 (overflow, stop); a HALT high byte is written then stops.
  logic [7:0]  bytes[$];
  logic [31:0] exp_q[$];
  logic        exp_ovf;

  function automatic void build_model(input int aw);
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; 2*k+1 < bytes.size(); k++) begin
      int addr = 1 + k;
      if (addr > (1 << aw) - 1) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_q.push_back({addr[15:0], bytes[2*k], bytes[2*k+1]});
      if (bytes[2*k] == 8'hE0) break;
    end
  endfunction

  task automatic cmp_all(input string tag, input bit is_b);
    logic [31:0] got[$];
    logic [31:0] mx, ov, dn, emx;
    build_model(is_b ? 3 : 8);
    if (is_b) begin
      got = wq_b; mx = 32'(max_b); ov = 32'(ovf_b); dn = 32'(done_b);
    end else begin
      got = wq_a; mx = 32'(max_a); ov = 32'(ovf_a); dn = 32'(done_a);
    end
    chk({tag, "_nwr"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got[i], exp_q[i]);
    emx = (exp_q.size() > 0) ? 32'(exp_q[exp_q.size()-1][31:16]) : 32'h0;
    chk({tag, "_max"}, mx, emx);
    chk({tag, "_ovf"}, ov, 32'(exp_ovf));
    chk({tag, "_done"}, dn, 32'((exp_q.size() > 0) || exp_ovf));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we_a"},   32'(if_a.mem_we), 0);
    chk({tag, "_addr_a"}, 32'(if_a.mem_addr), 0);
    chk({tag, "_wd_a"},   32'(if_a.mem_wdata), 0);
    chk({tag, "_done_a"}, 32'(done_a), 0);
    chk({tag, "_max_a"},  32'(max_a), 0);
    chk({tag, "_ovf_a"},  32'(ovf_a), 0);
    chk({tag, "_run_a"},  32'(run_a), 0);
    chk({tag, "_we_b"},   32'(if_b.mem_we), 0);
    chk({tag, "_done_b"}, 32'(done_b), 0);
    chk({tag, "_max_b"},  32'(max_b), 0);
    chk({tag, "_run_b"},  32'(run_b), 0);
  endtask

  // All tasks start and end just after a negedge.
  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    bytes.delete();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    bytes.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!(done_a && done_b) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!(done_a && done_b)) chk("wait_done_timeout", 32'(n), 32'(lim + 1));
  endtask

  logic [7:0] tp[18] = '{8'h41, 8'hFF, 8'h11, 8'h7F, 8'h81, 8'h80, 8'h41, 8'hFF, 8'h10,
                         8'h80, 8'h81, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'h20, 8'hE0, 8'h00};

  function automatic logic [7:0] rnd_hi();
    logic [7:0] h = 8'($urandom);
    if (h == 8'hE0) h = 8'hE1;
    return h;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);

    // Fixed program ending in HALT
    do_reset();
    foreach (tp[i]) send_byte(tp[i], (i % 3 == 0) ? 0 : int'($urandom_range(0, 2)));
    repeat (3) @(negedge clk);
    chk("halt_done_lat", 32'(done_rise_a - last_we_a), 1);
    cmp_all("halt_a", 0);
    cmp_all("halt_b", 1);
    // Bytes after done are ignored
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    repeat (3) @(negedge clk);
    cmp_all("post_a", 0);
    cmp_all("post_b", 1);

    // Idle timeout after 2 words, start held early must not run or truncate
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(i[0] ? 8'($urandom) : rnd_hi(), 1);
    start = 1'b0;
    bytes.delete();
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(i[0] ? 8'($urandom) : rnd_hi(), 2);
    send_byte(8'($urandom), 0);
    repeat (500) @(negedge clk);
    chk("early_run_a", 32'(run_a), 0);
    chk("early_done_a", 32'(done_a), 0);
    start = 1'b0;
    repeat (TO - 1 - 500) @(negedge clk);
    chk("to999_a", 32'(done_a), 0);
    chk("to999_b", 32'(done_b), 0);
    @(negedge clk);
    chk("to1000_a", 32'(done_a), 1);
    chk("to1000_b", 32'(done_b), 1);
    cmp_all("to_a", 0);
    cmp_all("to_b", 1);
    chk("to_run_idle", 32'(run_a), 0);
    start = 1'b1;
    @(negedge clk);
    chk("run_on_a", 32'(run_a), 1);
    chk("run_on_b", 32'(run_b), 1);
    start = 1'b0;
    @(negedge clk);
    chk("run_off_a", 32'(run_a), 0);
    chk("run_off_done_a", 32'(done_a), 1);

    // Timeout with a trailing high byte pending
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(i[0] ? 8'($urandom) : rnd_hi(), 0);
    repeat (TO - 1) @(negedge clk);
    chk("tr999_a", 32'(done_a), 0);
    @(negedge clk);
    chk("tr1000_a", 32'(done_a), 1);
    cmp_all("trail_a", 0);
    cmp_all("trail_b", 1);

    // 8 non-HALT words: small instance overflows
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(i[0] ? 8'($urandom) : rnd_hi(), int'($urandom_range(0, 1)));
    wait_done(TO + 20);
    cmp_all("ovf_a", 0);
    cmp_all("ovf_b", 1);

    // Reset after 1.5 words, then reload one word
    do_reset();
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 1);
    chk("mid_max_a", 32'(max_a), 1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    bytes.delete();
    @(negedge clk);
    send_byte(8'h41, 0); send_byte(8'h00, 1);
    chk("reload_nwr", 32'(wq_a.size()), 1);
    if (wq_a.size() > 0) chk("reload_wr", wq_a[0], 32'h0001_4100);
    wait_done(TO + 20);
    cmp_all("reload_a", 0);

    // Randomised programs: random lengths, gaps, HALT or timeout endings
    for (int r = 0; r < 6; r++) begin
      int nw = int'($urandom_range(1, 12));
      bit halted = 0;
      do_reset();
      for (int w = 0; w < nw; w++) begin
        logic [7:0] h = rnd_hi();
        if (w == nw - 1 && $urandom_range(0, 1) == 1) begin
          h = 8'hE0;
          halted = 1;
        end
        send_byte(h, int'($urandom_range(0, 3)));
        send_byte(8'($urandom), int'($urandom_range(0, 3)));
      end
      if (!halted && $urandom_range(0, 3) == 0) send_byte(rnd_hi(), 0);
      wait_done(TO + 20);
      cmp_all($sformatf("rnd%0d_a", r), 0);
      cmp_all($sformatf("rnd%0d_b", r), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
